// File: rtl/fec_pkg.sv
// Shared state encoding and rate table for the FEC block controller.
package fec_pkg;

  localparam int unsigned NUM_RATES = 7;

  typedef enum logic [2:0] {
    StIdle,
    StData,
    StTail,
    StParity,
    StDone
  } fec_state_e;

  // One row of the rate table: block length K, parity count P, RS bypass, puncturing select.
  typedef struct packed {
    logic [6:0] k;
    logic [4:0] p;
    logic       bypass;
    logic [1:0] punct;
  } rate_entry_t;

  // Index 0 is the rightmost element.
  localparam rate_entry_t [NUM_RATES-1:0] RATE_TABLE = {
    rate_entry_t'{k: 7'd108, p: 5'd12, bypass: 1'b0, punct: 2'd3},
    rate_entry_t'{k: 7'd96,  p: 5'd12, bypass: 1'b0, punct: 2'd2},
    rate_entry_t'{k: 7'd72,  p: 5'd8,  bypass: 1'b0, punct: 2'd3},
    rate_entry_t'{k: 7'd48,  p: 5'd16, bypass: 1'b0, punct: 2'd1},
    rate_entry_t'{k: 7'd36,  p: 5'd4,  bypass: 1'b0, punct: 2'd3},
    rate_entry_t'{k: 7'd24,  p: 5'd8,  bypass: 1'b0, punct: 2'd1},
    rate_entry_t'{k: 7'd12,  p: 5'd0,  bypass: 1'b1, punct: 2'd0}
  };

endpackage

// File: rtl/fec_rate_lut.sv
// Combinational rate-table lookup: rate id to block parameters plus a valid flag.
module fec_rate_lut (
  input  logic [3:0] rate_id_i,
  output logic [6:0] k_o,
  output logic [4:0] p_o,
  output logic       bypass_o,
  output logic [1:0] punct_o,
  output logic       valid_o
);
  import fec_pkg::*;

  localparam logic [3:0] NumRatesId = 4'(NUM_RATES);

  rate_entry_t entry;

  always_comb begin
    entry   = '0;
    valid_o = 1'b0;
    if (rate_id_i < NumRatesId) begin
      valid_o = 1'b1;
      entry   = RATE_TABLE[rate_id_i[2:0]];
    end
  end

  assign k_o      = entry.k;
  assign p_o      = entry.p;
  assign bypass_o = entry.bypass;
  assign punct_o  = entry.punct;

endmodule

// File: rtl/fec_ctrl.sv
// FEC block controller: passes K-1 MAC bytes to the RS encoder, appends a zero tail byte,
// then requests P parity bytes. Optional abort input when FEC_CTRL_ABORT_EN is defined.
module fec_ctrl (
  input  logic       clk,
  input  logic       reset,
`ifdef FEC_CTRL_ABORT_EN
  input  logic       abort,
`endif
  input  logic       start,
  input  logic [3:0] cfg_rate_id,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] rs_data,
  output logic       rs_valid,
  input  logic       rs_ready,
  output logic       rs_par_en,
  output logic       rs_bypass,
  output logic [1:0] cc_punct_id,
  output logic       busy,
  output logic       done,
  output logic       err
);
  import fec_pkg::*;

  logic [6:0] lut_k;
  logic [4:0] lut_p;
  logic       lut_bypass;
  logic [1:0] lut_punct;
  logic       lut_valid;

  fec_rate_lut u_rate_lut (
    .rate_id_i (cfg_rate_id),
    .k_o       (lut_k),
    .p_o       (lut_p),
    .bypass_o  (lut_bypass),
    .punct_o   (lut_punct),
    .valid_o   (lut_valid)
  );

  fec_state_e state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic [6:0] k_m1_q, k_m1_d;
  logic [4:0] p_q, p_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       par_en_q, par_en_d;
  logic       bypass_q, bypass_d;
  logic [1:0] punct_q, punct_d;
  logic [6:0] cnt_inc;
  logic       abort_act;

`ifdef FEC_CTRL_ABORT_EN
  assign abort_act = abort && (state_q != StIdle);
`else
  assign abort_act = 1'b0;
`endif

  assign cnt_inc = cnt_q + 7'd1;

  // Abort blocks any handshake in its cycle so no byte is lost mid-transfer.
  always_comb begin
    in_ready = 1'b0;
    rs_valid = 1'b0;
    rs_data  = 8'h00;
    case (state_q)
      StData: begin
        in_ready = rs_ready & ~abort_act;
        rs_valid = in_valid & ~abort_act;
        rs_data  = in_data;
      end
      StTail: begin
        rs_valid = ~abort_act;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    k_m1_d   = k_m1_q;
    p_d      = p_q;
    bypass_d = bypass_q;
    punct_d  = punct_q;
    err_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          if (lut_valid) begin
            state_d  = StData;
            cnt_d    = '0;
            k_m1_d   = lut_k - 7'd1;
            p_d      = lut_p;
            bypass_d = lut_bypass;
            punct_d  = lut_punct;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StData: begin
        if (in_valid && in_ready) begin
          cnt_d = cnt_inc;
          if (cnt_inc == k_m1_q) begin
            state_d = StTail;
            cnt_d   = '0;
          end
        end
      end
      StTail: begin
        if (rs_ready) begin
          state_d = (p_q != '0) ? StParity : StDone;
        end
      end
      StParity: begin
        if (rs_ready) begin
          cnt_d = cnt_inc;
          if (cnt_inc == {2'b00, p_q}) begin
            state_d = StDone;
            cnt_d   = '0;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (abort_act) begin
      state_d = StIdle;
      cnt_d   = '0;
    end

    // Block configuration is only presented while a block is in flight.
    if (state_d == StIdle) begin
      bypass_d = 1'b0;
      punct_d  = 2'd0;
    end

    busy_d   = (state_d != StIdle);
    done_d   = (state_d == StDone);
    par_en_d = (state_d == StParity);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      k_m1_q   <= '0;
      p_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      par_en_q <= 1'b0;
      bypass_q <= 1'b0;
      punct_q  <= 2'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      k_m1_q   <= k_m1_d;
      p_q      <= p_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      par_en_q <= par_en_d;
      bypass_q <= bypass_d;
      punct_q  <= punct_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign rs_par_en   = par_en_q;
  assign rs_bypass   = bypass_q;
  assign cc_punct_id = punct_q;

endmodule

// File: tb/tb_fec_ctrl.sv
// Bench for fec_ctrl: start-vector table, directed block/reset sequences and randomized blocks
// scored against a transaction-level model. Define FEC_CTRL_ABORT_EN to also exercise abort.
module tb_fec_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] cfg_rate_id;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] rs_data;
  logic       rs_valid;
  logic       rs_ready;
  logic       rs_par_en;
  logic       rs_bypass;
  logic [1:0] cc_punct_id;
  logic       busy;
  logic       done;
  logic       err;
`ifdef FEC_CTRL_ABORT_EN
  logic       abort;
`endif

  fec_ctrl dut (
    .clk         (clk),
    .reset       (reset),
`ifdef FEC_CTRL_ABORT_EN
    .abort       (abort),
`endif
    .start       (start),
    .cfg_rate_id (cfg_rate_id),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .rs_data     (rs_data),
    .rs_valid    (rs_valid),
    .rs_ready    (rs_ready),
    .rs_par_en   (rs_par_en),
    .rs_bypass   (rs_bypass),
    .cc_punct_id (cc_punct_id),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference rate table.
  int k_tab   [7] = '{12, 24, 36, 48, 72, 96, 108};
  int p_tab   [7] = '{0, 8, 4, 16, 8, 12, 12};
  int byp_tab [7] = '{1, 0, 0, 0, 0, 0, 0};
  int pun_tab [7] = '{0, 1, 3, 1, 3, 2, 3};

  typedef struct {
    logic [3:0] id;
    bit         err;
    bit         busy;
    bit         rdy;
    logic [1:0] punct;
    bit         byp;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int all_outs();
    return int'({in_ready, rs_valid, rs_par_en, busy, done, err, rs_bypass, cc_punct_id, rs_data});
  endfunction

  // Runs one block from IDLE and scores it as a transaction: stream = accepted bytes + 0x00,
  // P parity requests with rs_ready, exactly one done, constant config while busy.
  task automatic run_block(input int id, input int rdy_mode, input int vld_mode,
                           input bit rand_start, input bit check_lat, input string tag);
    logic [7:0] q_exp[$];
    logic [7:0] q_got[$];
    int n_par = 0, n_done = 0, done_at = -1, bad_cfg = 0, bad_pass = 0;
    int n_err = 0, n_mis = 0, cyc_n = 0, n_in;
    bit fin = 1'b0;
    start = 1'b1; cfg_rate_id = 4'(id); in_valid = 1'b0; rs_ready = 1'b0;
    cyc();
    start = 1'b0;
    while (!fin && cyc_n < 3000) begin
      cyc_n++;
      case (rdy_mode)
        0:       rs_ready = 1'b1;
        1:       rs_ready = ((cyc_n % 2) == 1);
        default: rs_ready = 1'($urandom_range(0, 1));
      endcase
      in_valid    = (vld_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      in_data     = 8'($urandom);
      start       = rand_start && ($urandom_range(0, 5) == 0);
      cfg_rate_id = 4'($urandom);
      #1;
      if (in_valid && in_ready) q_exp.push_back(in_data);
      if (rs_valid && rs_ready) q_got.push_back(rs_data);
      if (rs_par_en && rs_ready) n_par++;
      if (rs_par_en && (in_ready || rs_valid)) bad_pass++;
      if (in_ready && (!rs_ready || rs_valid != in_valid || rs_data != in_data)) bad_pass++;
      if (!busy || rs_bypass != 1'(byp_tab[id]) || cc_punct_id != 2'(pun_tab[id])) bad_cfg++;
      if (err) n_err++;
      if (done) begin
        n_done++;
        done_at = cyc_n;
        fin = 1'b1;
      end
      cyc();
    end
    start = 1'b0; in_valid = 1'b1; rs_ready = 1'b1;
    #1;
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_done"}, done, 0);
    chk({tag, "_idle_cfg"}, {rs_bypass, cc_punct_id}, 0);
    chk({tag, "_idle_in_ready"}, in_ready, 0);
    n_in = q_exp.size();
    q_exp.push_back(8'h00);
    chk({tag, "_in_bytes"}, n_in, k_tab[id] - 1);
    chk({tag, "_rs_bytes"}, q_got.size(), q_exp.size());
    for (int i = 0; i < q_got.size() && i < q_exp.size(); i++) begin
      if (q_got[i] != q_exp[i]) n_mis++;
    end
    chk({tag, "_stream_order"}, n_mis, 0);
    chk({tag, "_parity_cycles"}, n_par, p_tab[id]);
    chk({tag, "_done_pulses"}, n_done, 1);
    chk({tag, "_cfg_hold"}, bad_cfg, 0);
    chk({tag, "_handshake"}, bad_pass, 0);
    chk({tag, "_no_err"}, n_err, 0);
    if (check_lat) chk({tag, "_done_cycle"}, done_at, k_tab[id] + p_tab[id] + 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int ntx;
    reset = 1'b1; start = 1'b0; cfg_rate_id = 4'd0; in_data = 8'h00;
    in_valid = 1'b1; rs_ready = 1'b1;
`ifdef FEC_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) cyc();
    chk("reset_outputs", all_outs(), 0);
    reset = 1'b0;
    cyc();

    // Start vectors: every rate id from IDLE, one cycle later state is checked, then reset.
    vecs[0] = '{4'd0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1};
    vecs[1] = '{4'd1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0};
    vecs[2] = '{4'd2, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0};
    vecs[3] = '{4'd3, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0};
    vecs[4] = '{4'd4, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0};
    vecs[5] = '{4'd5, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0};
    vecs[6] = '{4'd6, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0};
    for (int i = 7; i < 16; i++) vecs[i] = '{4'(i), 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};

    for (int i = 0; i < 16; i++) begin
      start = 1'b1; cfg_rate_id = vecs[i].id; in_valid = 1'b1; rs_ready = 1'b1;
      cyc();
      start = 1'b0;
      #1;
      chk($sformatf("vec%0d_err", i), err, vecs[i].err);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].rdy);
      chk($sformatf("vec%0d_punct", i), cc_punct_id, vecs[i].punct);
      chk($sformatf("vec%0d_bypass", i), rs_bypass, vecs[i].byp);
      cyc();
      chk($sformatf("vec%0d_err_one_cycle", i), err, 0);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
    end

    // Directed blocks.
    run_block(1, 0, 0, 1'b0, 1'b1, "id1_full_rate");
    run_block(0, 0, 0, 1'b0, 1'b1, "id0_bypass");
    run_block(2, 1, 0, 1'b0, 1'b0, "id2_toggle_ready");

    // Reset in the parity phase of id3, then a clean id4 block.
    start = 1'b1; cfg_rate_id = 4'd3; in_valid = 1'b1; rs_ready = 1'b1;
    cyc();
    start = 1'b0;
    cnt = 0;
    while (!rs_par_en && cnt < 200) begin
      cyc();
      cnt++;
    end
    chk("id3_reached_parity", rs_par_en, 1);
    repeat (3) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    chk("id3_reset_outputs", all_outs(), 0);
    run_block(4, 0, 0, 1'b0, 1'b1, "id4_after_reset");

`ifdef FEC_CTRL_ABORT_EN
    // Abort id5 at data byte 10 (0-based); a start while busy must be ignored.
    start = 1'b1; cfg_rate_id = 4'd5; in_valid = 1'b1; rs_ready = 1'b1;
    cyc();
    ntx = 0;
    for (int c = 1; c <= 10; c++) begin
      start = (c == 5); cfg_rate_id = 4'd1;
      #1;
      if (in_valid && in_ready) ntx++;
      cyc();
    end
    chk("abort_pre_bytes", ntx, 10);
    chk("abort_start_ignored_punct", cc_punct_id, 2);
    abort = 1'b1; start = 1'b1; cfg_rate_id = 4'd1;
    #1;
    chk("abort_blocks_transfer", in_ready, 0);
    cyc();
    abort = 1'b0; start = 1'b0;
    #1;
    chk("abort_idle_outputs", all_outs(), 0);
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (done || busy) cnt++;
      cyc();
    end
    chk("abort_no_done", cnt, 0);
`else
    ntx = 0;
`endif

    // Randomized blocks with random handshakes and spurious start pulses.
    for (int b = 0; b < 16; b++) begin
      run_block(int'($urandom_range(0, 6)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 1)), 1'b1, 1'b0, $sformatf("rnd%0d", b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fec_ctrl.md
FEC_CTRL -- requirements
Module: fec_ctrl

Interface
REQ-001 clk  input  1  single clock; all logic on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 start  input  1  one-cycle pulse; begins one FEC block using cfg_rate_id; honoured only in IDLE.
REQ-004 cfg_rate_id  input  4  rate index (table REQ-010); sampled on the start cycle.
REQ-005 in_data / in_valid / in_ready  input 8 / input 1 / output 1  uncoded byte stream from MAC; a byte transfers when in_valid&in_ready.
REQ-006 rs_data / rs_valid / rs_ready  output 8 / output 1 / input 1  byte stream to the RS encoder; a byte transfers when rs_valid&rs_ready.
REQ-007 rs_par_en  output  1  requests one parity byte from the RS encoder per cycle with rs_ready high; rs_bypass  output 1  RS disabled for this block.
REQ-008 cc_punct_id  output  2  puncturing select (0=1/2, 1=2/3, 2=3/4, 3=5/6), held for the whole block.
REQ-009 busy  output  1  high outside IDLE; done  output 1  one-cycle pulse at block end; err  output 1  one-cycle pulse when start has an invalid rate_id.

Function
REQ-010 Rate table: id0 K=12, P=0, bypass, punct 0; id1 K=24, P=8, punct 1; id2 K=36, P=4, punct 3; id3 K=48, P=16, punct 1; id4 K=72, P=8, punct 3; id5 K=96, P=12, punct 2; id6 K=108, P=12, punct 3; id7-15 invalid.
REQ-011 States: IDLE, DATA, TAIL, PARITY, DONE; encoded as a one-hot or binary enum declared in the package.
REQ-012 IDLE: start with valid id -> DATA, latch K/P/bypass/punct, clear byte counter; start with invalid id -> err pulse, stay IDLE.
REQ-013 DATA: in_ready = rs_ready; rs_data = in_data; rs_valid = in_valid; counter increments per transfer; after transfer K-1 -> TAIL.
REQ-014 TAIL: rs_data = 8'h00, rs_valid = 1, in_ready = 0; on rs_ready -> PARITY if P>0, else DONE.
REQ-015 PARITY: rs_par_en = 1; counter counts cycles with rs_ready high; after P counted -> DONE; in_ready = 0, rs_valid = 0.
REQ-016 DONE: done = 1 for exactly one cycle, then IDLE; start in the DONE cycle is ignored.
REQ-017 start while busy is ignored; it never restarts or corrupts the block.
REQ-018 Counter is 7 bits, never wraps; the comparison is against the latched K-1 or P.
REQ-019 rs_bypass and cc_punct_id hold their latched values from the cycle after start until IDLE is re-entered.
REQ-020 in_ready and rs_valid are combinational from state and the handshake inputs; no other combinational input-to-output paths.

Reset
REQ-021 reset forces IDLE; busy, done, err, rs_valid, rs_par_en, in_ready, rs_bypass = 0; cc_punct_id = 0; counter = 0.
REQ-022 Reset mid-block abandons the block without a done pulse; the first post-reset cycle accepts start.

Configuration
REQ-023 Macro FEC_CTRL_ABORT_EN: when defined, adds input abort (1 bit); abort high in any non-IDLE state returns to IDLE next cycle with no done pulse. Abort has priority over start and handshake transfers in that cycle. When undefined, there is no port and no logic.

Structure
REQ-024 Package fec_pkg holds the state enum, the rate-table typedef (K, P, bypass, punct), the constant table, and NUM_RATES=7.
REQ-025 Sub-module fec_rate_lut (combinational id -> table entry plus valid flag) is instantiated once.

Verification
REQ-026 start id1, in_valid and rs_ready always high -> 23 input transfers, 1 byte 0x00, 8 rs_par_en cycles, done at cycle 33 after start, cc_punct_id = 1.
REQ-027 start id0 -> 11 input bytes, tail 0x00, no rs_par_en, rs_bypass = 1, done pulse.
REQ-028 start id9 -> err pulse, busy stays 0, no in_ready.
REQ-029 id2 with rs_ready toggling every other cycle -> exactly 35 input bytes pass, byte order preserved, 4 parity cycles counted only while rs_ready is high.
REQ-030 reset asserted in PARITY of id3 -> all outputs 0 next cycle; following start id4 completes normally with K=72 and P=8.
REQ-031 (FEC_CTRL_ABORT_EN) abort at DATA byte 10 of id5 -> IDLE next cycle, no done; second start while busy ignored.
